run_controller: RTL
===================

# run_controller

Sequencing controller for the pipelined MIPS core in debug/run mode. It turns host commands (run, single/multi-step, halt, clear) into the `clkEnable` strobe for the pipeline. It watches the end-of-program flag from the end-program detector, and generates the `clear_program_finished` pulse that re-arms that detector. It sits between the debug/UART command front-end and the pipeline plus end-program detector, and it also keeps an executed-cycle counter and a watchdog.

## Interface
- `CNT_W`, default 32: width of `cycle_count`.
- `STEP_LEN`, default 1: number of enabled pipeline cycles per STEP command (≥1).
- `MAX_CYCLES`, default 0: watchdog limit in enabled cycles for RUN; 0 disables the watchdog.

- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command strobe.
- `cmd`  in  2  command code: 00 HALT, 01 RUN, 10 STEP, 11 CLEAR.
- `cmd_ready`  out  1  command accepted this cycle when `cmd_valid & cmd_ready`.
- `program_end`  in  1  registered end flag from the end-program detector.
- `pipe_clk_enable`  out  1  clock-enable to the pipeline and the detector.
- `clear_program_finished`  out  1  re-arm pulse to the detector.
- `cycle_count`  out  `CNT_W`  enabled pipeline cycles since last CLEAR.
- `done`  out  1  one-cycle pulse on entry to FINISHED.
- `timeout`  out  1  sticky, set on watchdog expiry.
- `cmd_error`  out  1  one-cycle pulse when an accepted command is illegal in the current state.
- `state`  out  2  IDLE=00, RUN=01, STEP=10, CLEAR=11; FINISHED is reported as IDLE with `done`/`program_end` context. The internal FSM has 5 states, and `state` exposes the 2-bit encoding of the first four.

## Operation
- FSM states: IDLE, RUN, STEP, CLEAR, FINISHED.
- `cmd_ready` = 1 in IDLE, RUN and FINISHED; 0 in STEP and CLEAR. While `cmd_ready`=0, commands are not consumed and have no effect.
- `pipe_clk_enable` is combinational:
  - 1 in RUN when `program_end`=0 and there is no accepted HALT this cycle.
  - 1 in STEP when `program_end`=0.
  - 1 in CLEAR.
  - 0 otherwise, and forced 0 while `reset`=1.
- `clear_program_finished` = 1 exactly in the CLEAR state.
- IDLE behaviour:
  - RUN → RUN.
  - STEP → STEP, with step counter loaded to `STEP_LEN`.
  - CLEAR → CLEAR.
  - HALT: no-op.
  - RUN or STEP while `program_end`=1: stay in IDLE and pulse `cmd_error`.
- RUN behaviour:
  - `program_end`=1 → FINISHED, with `done` pulsed on entry.
  - Accepted HALT → IDLE.
  - Watchdog: `MAX_CYCLES`≠0 and `cycle_count` reaches `MAX_CYCLES` → IDLE and set `timeout`.
  - Other accepted commands: pulse `cmd_error`, no effect.
  - Priority: `program_end` > watchdog > HALT.
- STEP behaviour:
  - Decrement the step counter on each enabled cycle.
  - On the cycle the counter hits 0 → IDLE.
  - `program_end`=1 → FINISHED, with priority over step completion.
- CLEAR behaviour:
  - Lasts exactly 1 cycle, with enable and clear both high.
  - Zeroes `cycle_count` and clears `timeout`.
  - Next state: IDLE.
- FINISHED behaviour:
  - CLEAR → CLEAR.
  - HALT: no-op.
  - RUN or STEP → `cmd_error`.
- `cycle_count` increments by 1 on every cycle with `pipe_clk_enable`=1 outside CLEAR. It saturates at 2^`CNT_W`−1 with no wrap.

## Timing
- Reset values, applied on the clock edge with `reset`=1:
  - State IDLE.
  - `cycle_count`=0, `timeout`=0, `done`=0, `cmd_error`=0, step counter 0.
  - `pipe_clk_enable`, `clear_program_finished` and `cmd_ready` follow from the IDLE decode.
- Reset mid-RUN or mid-STEP: `pipe_clk_enable` goes 0 in the reset cycle itself, and the FSM is in IDLE on the following cycle.
- Command latency: a command accepted at edge N puts the FSM in the new state after edge N. The first `pipe_clk_enable` for RUN or STEP is in cycle N+1.
- STEP with `STEP_LEN`=k: `pipe_clk_enable` high for exactly k consecutive cycles, then IDLE.
- End detection: the detector raises `program_end` one cycle after its 4th enabled NOP edge. `pipe_clk_enable` drops combinationally in the same cycle `program_end` is seen, so there is no extra pipeline advance. FINISHED is entered at the next edge.
- HALT accepted in RUN: enable is 0 in that same cycle.
- `done` and `cmd_error` are registered, high for exactly one cycle after the triggering edge.

## Test plan
- Reset, then RUN at cycle 2; drive `program_end`=1 at cycle 12 → `pipe_clk_enable` high for cycles 3–11 and low from 12; `cycle_count`=9; `done` pulses once; state FINISHED.
- `STEP_LEN`=3, issue STEP in IDLE → enable high for exactly 3 cycles; `cycle_count`=3; `cmd_ready`=0 during those cycles; IDLE afterwards.
- From FINISHED, issue RUN → `cmd_error` pulse, no enable. Then issue CLEAR → exactly 1 cycle with `clear_program_finished`=1 and `pipe_clk_enable`=1; `cycle_count`=0; then IDLE.
- `MAX_CYCLES`=5, issue RUN with `program_end` held at 0 → 5 enabled cycles, then IDLE with `timeout`=1. A following CLEAR drops `timeout`.
- During RUN, issue HALT in the same cycle `program_end` rises → FINISHED wins, `done`=1, enable 0 that cycle.
- Assert `reset` in the 4th cycle of RUN → enable 0 in that cycle; next cycle IDLE with `cycle_count`=0 and all flags 0.

Source files
------------

// File: rtl/run_controller.sv
// Run/step sequencing controller for the pipelined core in debug mode: turns host
// commands into the pipeline clock-enable and re-arms the end-program detector.
`timescale 1ns/1ps

module run_controller #(
  parameter int CNT_W      = 32,
  parameter int STEP_LEN   = 1,
  parameter int MAX_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic             program_end,
  output logic             pipe_clk_enable,
  output logic             clear_program_finished,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             timeout,
  output logic             cmd_error,
  output logic [1:0]       state
);

  localparam int STEP_W = (STEP_LEN < 2) ? 1 : $clog2(STEP_LEN + 1);
  localparam logic [STEP_W-1:0] LP_STEP_LOAD = STEP_W'(STEP_LEN);

  localparam logic [1:0] CMD_HALT  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_STEP     = 3'd2,
    S_CLEAR    = 3'd3,
    S_FINISHED = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [STEP_W-1:0]   w_step_cnt_next;
  logic [CNT_W-1:0]    r_cycle_count;
  logic [CNT_W-1:0]    w_cycle_count_next;
  logic                r_done;
  logic                r_cmd_error;
  logic                w_cmd_error_next;
  logic                r_timeout;
  logic                w_timeout_next;

  logic                w_accept;
  logic                w_halt_acc;
  logic                w_run_enable;
  logic                w_wd_at_limit;
  logic                w_wd_reach;

  assign cmd_ready  = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_FINISHED);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_halt_acc = w_accept && (cmd == CMD_HALT);

  // Enable is held off once the watchdog limit is already reached, so RUN never
  // advances the pipeline past MAX_CYCLES.
  assign w_run_enable = (r_state == S_RUN) && !program_end && !w_halt_acc && !w_wd_at_limit;

  assign pipe_clk_enable = !reset && (w_run_enable
                                      || ((r_state == S_STEP) && !program_end)
                                      || (r_state == S_CLEAR));

  assign clear_program_finished = (r_state == S_CLEAR);

  generate
    if (MAX_CYCLES != 0) begin : g_watchdog
      localparam logic [CNT_W:0] LP_MAX = (CNT_W + 1)'(MAX_CYCLES);
      logic [CNT_W:0] w_count_after;
      assign w_count_after = {1'b0, r_cycle_count} + (CNT_W + 1)'(w_run_enable);
      assign w_wd_at_limit = ({1'b0, r_cycle_count} >= LP_MAX);
      assign w_wd_reach    = (w_count_after >= LP_MAX);
    end else begin : g_no_watchdog
      assign w_wd_at_limit = 1'b0;
      assign w_wd_reach    = 1'b0;
    end
  endgenerate

  // Cycle counter: cleared by CLEAR, otherwise counts enabled cycles and saturates.
  always_comb begin
    w_cycle_count_next = r_cycle_count;
    if (r_state == S_CLEAR) begin
      w_cycle_count_next = '0;
    end else if (pipe_clk_enable && (r_cycle_count != {CNT_W{1'b1}})) begin
      w_cycle_count_next = r_cycle_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_step_cnt_next  = r_step_cnt;
    w_cmd_error_next = 1'b0;
    w_timeout_next   = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd)
            CMD_RUN: begin
              if (program_end) w_cmd_error_next = 1'b1;
              else             w_state_next     = S_RUN;
            end
            CMD_STEP: begin
              if (program_end) begin
                w_cmd_error_next = 1'b1;
              end else begin
                w_state_next    = S_STEP;
                w_step_cnt_next = LP_STEP_LOAD;
              end
            end
            CMD_CLEAR: w_state_next = S_CLEAR;
            default:   ;
          endcase
        end
      end
      S_RUN: begin
        if (program_end) begin
          w_state_next = S_FINISHED;
        end else if (w_wd_reach) begin
          w_state_next   = S_IDLE;
          w_timeout_next = 1'b1;
        end else if (w_halt_acc) begin
          w_state_next = S_IDLE;
        end
        if (w_accept && (cmd != CMD_HALT)) w_cmd_error_next = 1'b1;
      end
      S_STEP: begin
        if (program_end) begin
          w_state_next = S_FINISHED;
        end else if (r_step_cnt > STEP_W'(1)) begin
          w_step_cnt_next = r_step_cnt - STEP_W'(1);
        end else begin
          w_step_cnt_next = '0;
          w_state_next    = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_state_next   = S_IDLE;
        w_timeout_next = 1'b0;
      end
      S_FINISHED: begin
        if (w_accept) begin
          case (cmd)
            CMD_CLEAR: w_state_next     = S_CLEAR;
            CMD_RUN:   w_cmd_error_next = 1'b1;
            CMD_STEP:  w_cmd_error_next = 1'b1;
            default:   ;
          endcase
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_step_cnt    <= '0;
      r_cycle_count <= '0;
      r_done        <= 1'b0;
      r_cmd_error   <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_step_cnt    <= w_step_cnt_next;
      r_cycle_count <= w_cycle_count_next;
      r_done        <= (w_state_next == S_FINISHED) && (r_state != S_FINISHED);
      r_cmd_error   <= w_cmd_error_next;
      r_timeout     <= w_timeout_next;
    end
  end

  // FINISHED is reported externally as IDLE.
  always_comb begin
    state = 2'b00;
    case (r_state)
      S_RUN:   state = 2'b01;
      S_STEP:  state = 2'b10;
      S_CLEAR: state = 2'b11;
      default: state = 2'b00;
    endcase
  end

  assign cycle_count = r_cycle_count;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cmd_error   = r_cmd_error;

endmodule
